// File: rtl/ws2812_serializer.sv
// WS2812 single-wire serializer: snapshots a GRB frame on request, shifts it out MSB-first
// as pulse-width-coded bits, then holds the line low for the latch period.
module ws2812_serializer #(
    parameter int NUM_LEDS = 5,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int TBIT     = 62,
    parameter int TRST     = 2600
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [24*NUM_LEDS-1:0]  GRBSeq,
    input  logic                    Load,
    output logic                    Dout,
    output logic                    Busy,
    output logic                    Done
);

    localparam int FW   = 24 * NUM_LEDS;
    localparam int BI_W = $clog2(FW);
    localparam int PH_W = $clog2(TBIT);
    localparam int LC_W = $clog2(TRST);

    localparam logic [BI_W-1:0] LAST_BIT = BI_W'(FW - 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(TBIT - 1);
    localparam logic [PH_W-1:0] T0H_C    = PH_W'(T0H);
    localparam logic [PH_W-1:0] T1H_C    = PH_W'(T1H);
    localparam logic [LC_W-1:0] LC_LAST  = LC_W'(TRST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_SEND,
        S_LATCH
    } state_t;

    state_t            state_q,   state_d;
    logic [FW-1:0]     shreg_q,   shreg_d;
    logic [BI_W-1:0]   bit_idx_q, bit_idx_d;
    logic [PH_W-1:0]   phase_q,   phase_d;
    logic [LC_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic              pending_q, pending_d;
    logic              framed_q,  framed_d;
    logic              dout_q,    dout_d;
    logic              done_q,    done_d;

    // Reset lands in LATCH so a truncated frame still gets a full low period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LATCH;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            phase_q   <= '0;
            lat_cnt_q <= '0;
            pending_q <= 1'b0;
            framed_q  <= 1'b0;
            dout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            phase_q   <= phase_d;
            lat_cnt_q <= lat_cnt_d;
            pending_q <= pending_d;
            framed_q  <= framed_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        phase_d   = phase_q;
        lat_cnt_d = lat_cnt_q;
        pending_d = pending_q;
        framed_d  = framed_q;
        dout_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Load) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (Load) begin
                    pending_d = 1'b1;
                end
                shreg_d   = GRBSeq;
                bit_idx_d = '0;
                phase_d   = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (Load) begin
                    pending_d = 1'b1;
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    shreg_d = {shreg_q[FW-2:0], 1'b0};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = S_LATCH;
                        lat_cnt_d = '0;
                        framed_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BI_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_LATCH: begin
                // A Load on the exit cycle is folded in so the request is not lost.
                if (lat_cnt_q == LC_LAST) begin
                    if (pending_q || Load) begin
                        state_d   = S_ARM;
                        pending_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LC_W'(1);
                    if (Load) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next-state values.
        if (state_d == S_SEND) begin
            dout_d = (phase_d < (shreg_d[FW-1] ? T1H_C : T0H_C));
        end
        if ((state_d == S_LATCH) && (lat_cnt_d == LC_LAST)) begin
            done_d = framed_d;
        end
    end

    assign Dout = dout_q;
    assign Done = done_q;
    assign Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer: records Dout edges, Done pulses and Busy drops by clock edge
// number and compares them against waveforms derived from the bit-timing rules.
module tb_ws2812_serializer;

    localparam int NUM_LEDS = 5;
    localparam int T0H      = 20;
    localparam int T1H      = 40;
    localparam int TBIT     = 62;
    localparam int TRST     = 2600;
    localparam int FW       = 24 * NUM_LEDS;

    logic          clk = 1'b0;
    logic          reset;
    logic [FW-1:0] GRBSeq;
    logic          Load;
    logic          Dout;
    logic          Busy;
    logic          Done;

    ws2812_serializer #(
        .NUM_LEDS(NUM_LEDS),
        .T0H     (T0H),
        .T1H     (T1H),
        .TBIT    (TBIT),
        .TRST    (TRST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .GRBSeq(GRBSeq),
        .Load  (Load),
        .Dout  (Dout),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rises[$];
    int   falls[$];
    int   dones[$];
    int   busy_falls[$];
    logic dout_prev = 1'b0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (Dout === 1'b1 && !dout_prev) rises.push_back(cyc);
        if (Dout !== 1'b1 && dout_prev)  falls.push_back(cyc);
        dout_prev = (Dout === 1'b1);
        if (Done === 1'b1) dones.push_back(cyc);
        if (Busy !== 1'b1 && busy_prev) busy_falls.push_back(cyc);
        busy_prev = (Busy === 1'b1);
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        rises.delete();
        falls.delete();
        dones.delete();
        busy_falls.delete();
    endtask

    task automatic pulse_load(output int k);
        Load = 1'b1;
        k = cyc + 1;
        step();
        Load = 1'b0;
    endtask

    task automatic wait_until(input int edge_no);
        while (cyc < edge_no) step();
    endtask

    task automatic wait_dones(input int target, input int budget, input string tag);
        int t = 0;
        while (dones.size() < target && t < budget) begin
            step();
            t++;
        end
        chk({tag, " done count"}, dones.size(), target);
    endtask

    task automatic wait_busy_fall(input int budget, input string tag);
        int t = 0;
        while (busy_falls.size() == 0 && t < budget) begin
            step();
            t++;
        end
        chk({tag, " busy drop seen"}, busy_falls.size(), 1);
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f = '0;
        for (int i = 0; i < NUM_LEDS; i++) f[i*24 +: 24] = 24'($urandom());
        return f;
    endfunction

    // Expected waveform: bit n rises at k+1+n*TBIT, stays high T1H or T0H, low for the rest.
    task automatic check_frame(input logic [FW-1:0] data, input int k, input int base,
                               input string tag);
        int nbad_r = 0;
        int nbad_h = 0;
        int nbad_l = 0;
        int w;
        chk({tag, " pulses present"}, (rises.size() >= base + FW && falls.size() >= base + FW), 1);
        if (rises.size() > base) chk({tag, " first rise edge"}, rises[base], k + 1);
        for (int n = 0; n < FW; n++) begin
            if (base + n + 1 < rises.size() && base + n < falls.size()) begin
                w = data[FW-1-n] ? T1H : T0H;
                if (rises[base+n] != k + 1 + n * TBIT) nbad_r++;
                if (falls[base+n] - rises[base+n] != w) nbad_h++;
                if (n < FW - 1 && rises[base+n+1] - falls[base+n] != TBIT - w) nbad_l++;
            end else if (base + n < rises.size() && base + n < falls.size()) begin
                w = data[FW-1-n] ? T1H : T0H;
                if (rises[base+n] != k + 1 + n * TBIT) nbad_r++;
                if (falls[base+n] - rises[base+n] != w) nbad_h++;
            end
        end
        chk({tag, " bits with wrong start"}, nbad_r, 0);
        chk({tag, " bits with wrong high width"}, nbad_h, 0);
        chk({tag, " bits with wrong low width"}, nbad_l, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, kx, r_edge;
        logic [FW-1:0] data, data2;

        reset  = 1'b1;
        Load   = 1'b0;
        GRBSeq = '0;

        // Reset behaviour and post-reset latch
        step();
        chk("reset Dout", Dout, 0);
        chk("reset Busy", Busy, 1);
        chk("reset Done", Done, 0);
        step();
        step();
        reset = 1'b0;
        r_edge = cyc;
        wait_busy_fall(TRST + 100, "post-reset");
        if (busy_falls.size() > 0) chk("post-reset busy drop edge", busy_falls[0], r_edge + TRST);
        chk("post-reset Dout stayed low", rises.size(), 0);
        chk("post-reset no Done", dones.size(), 0);
        step();
        chk("post-reset idle Busy", Busy, 0);

        // Single frame, one green LED at full scale
        clear_log();
        data = {24'h00FF00, {(FW-24){1'b0}}};
        GRBSeq = data;
        pulse_load(k);
        chk("t2 Busy in ARM", Busy, 1);
        wait_dones(1, FW * TBIT + TRST + 100, "t2");
        check_frame(data, k, 0, "t2");
        if (dones.size() > 0) chk("t2 done edge", dones[0], k + FW * TBIT + TRST);
        step();
        step();
        chk("t2 single done pulse", dones.size(), 1);
        chk("t2 idle Busy", Busy, 0);
        chk("t2 Done low", Done, 0);
        chk("t2 pulse count", rises.size(), FW);

        // Snapshot isolation: GRBSeq changes after ARM must not reach the line
        clear_log();
        data = rand_frame();
        GRBSeq = data;
        pulse_load(k);
        step();
        GRBSeq = '1;
        wait_until(k + 1 + 60 * TBIT + 7);
        GRBSeq = ~data;
        wait_dones(1, FW * TBIT + TRST + 100, "t3");
        check_frame(data, k, 0, "t3");
        step();
        step();

        // Pending: two loads during SEND yield exactly one extra frame
        clear_log();
        data  = rand_frame();
        data2 = rand_frame();
        GRBSeq = data;
        pulse_load(k);
        wait_until(k + 1 + 50 * TBIT + 10);
        pulse_load(kx);
        wait_until(k + 1 + 80 * TBIT + 30);
        GRBSeq = data2;
        pulse_load(kx);
        wait_dones(2, 2 * (FW * TBIT + TRST) + 200, "t4");
        check_frame(data, k, 0, "t4 frame1");
        if (dones.size() > 0) begin
            chk("t4 first done edge", dones[0], k + FW * TBIT + TRST);
            k2 = dones[0] + 1;
            check_frame(data2, k2, FW, "t4 frame2");
            if (dones.size() > 1) chk("t4 second done edge", dones[1], k2 + FW * TBIT + TRST);
        end
        repeat (10) step();
        chk("t4 total done pulses", dones.size(), 2);
        chk("t4 total pulses", rises.size(), 2 * FW);
        chk("t4 busy drops once", busy_falls.size(), 1);
        chk("t4 idle Busy", Busy, 0);

        // Reset mid-frame with a request pending
        clear_log();
        GRBSeq = rand_frame();
        pulse_load(k);
        wait_until(k + 1 + 40 * TBIT + 3);
        pulse_load(kx);
        wait_until(k + 1 + 50 * TBIT + 5);
        chk("t5 Dout high before reset", Dout, 1);
        reset = 1'b1;
        r_edge = cyc + 1;
        step();
        reset = 1'b0;
        chk("t5 Dout low after reset edge", Dout, 0);
        chk("t5 Busy after reset edge", Busy, 1);
        clear_log();
        wait_busy_fall(TRST + 100, "t5");
        if (busy_falls.size() > 0) chk("t5 busy drop edge", busy_falls[0], r_edge + TRST);
        repeat (5) step();
        chk("t5 no Done", dones.size(), 0);
        chk("t5 pending cleared, stays idle", Busy, 0);
        chk("t5 line low during latch", rises.size(), 0);

        clear_log();
        data = rand_frame();
        GRBSeq = data;
        pulse_load(k);
        wait_dones(1, FW * TBIT + TRST + 100, "t5b");
        check_frame(data, k, 0, "t5b");
        if (dones.size() > 0) chk("t5b done edge", dones[0], k + FW * TBIT + TRST);
        step();
        step();

        // Alternating pattern
        clear_log();
        data = {NUM_LEDS{24'hAAAAAA}};
        GRBSeq = data;
        pulse_load(k);
        wait_dones(1, FW * TBIT + TRST + 100, "t6");
        check_frame(data, k, 0, "t6");
        if (rises.size() > 1 && falls.size() > 1) begin
            chk("t6 bit0 high", falls[0] - rises[0], T1H);
            chk("t6 bit0 low", rises[1] - falls[0], TBIT - T1H);
            chk("t6 bit1 high", falls[1] - rises[1], T0H);
        end
        step();
        step();
        chk("t6 idle Busy", Busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
